// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if
//   Groups the pixel-timing inputs and the pattern outputs of vga_pattern_gen.
//   master : the timing source / observer (drives the i_* strobes, reads o_*).
//   slave  : the pattern generator itself.
//   Signals:
//     i_px_clk       pixel enable, one clk wide per pixel
//     i_haddr_en     horizontal active region
//     i_vaddr_en     vertical active region
//     i_mode_next    request to advance the pattern (single-clk pulse)
//     o_vga_red/green/blue  registered 4-bit colour
//     o_px_x/o_px_y  next pixel coordinate to be drawn
//     o_frame_start  one-clk pulse at the first active pixel of a frame
//     o_mode         pattern currently displayed
interface vga_pattern_gen_if;
  logic       i_px_clk;
  logic       i_haddr_en;
  logic       i_vaddr_en;
  logic       i_mode_next;
  logic [3:0] o_vga_red;
  logic [3:0] o_vga_green;
  logic [3:0] o_vga_blue;
  logic [9:0] o_px_x;
  logic [9:0] o_px_y;
  logic       o_frame_start;
  logic [1:0] o_mode;

  modport master (
    output i_px_clk, i_haddr_en, i_vaddr_en, i_mode_next,
    input  o_vga_red, o_vga_green, o_vga_blue, o_px_x, o_px_y, o_frame_start, o_mode
  );

  modport slave (
    input  i_px_clk, i_haddr_en, i_vaddr_en, i_mode_next,
    output o_vga_red, o_vga_green, o_vga_blue, o_px_x, o_px_y, o_frame_start, o_mode
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Test-pattern source for the 640x480 VGA pixel stage. Tracks the pixel
//   coordinate from the active-area enables, renders one of four patterns
//   (colour bars, checkerboard, gradient, border) and registers 4-bit RGB.
//   Pattern changes requested via i_mode_next take effect on the first pixel
//   of the next frame only.
//   Ports:
//     clk       system clock
//     i_sclr_n  asynchronous active-low reset
//     bus       vga_pattern_gen_if.slave (timing strobes in, RGB/coords out)
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BAR_W    = 80,
  parameter int CHK_LOG2 = 5
) (
  input logic              clk,
  input logic              i_sclr_n,
  vga_pattern_gen_if.slave bus
);

  logic [9:0]  x_q, y_q;
  logic [11:0] rgb_q;
  logic        fs_q;
  logic [1:0]  mode_q;
  logic        pending_q;
  logic        h_prev_q, v_prev_q;
  logic        armed_q;

  logic        tick, active, sof_cond, sof;
  logic [1:0]  mode_eff;
  logic [2:0]  bar;
  logic        border;
  logic [11:0] colour;

  assign tick   = bus.i_px_clk;
  assign active = tick & bus.i_haddr_en & bus.i_vaddr_en;

  // armed_q covers reset and vertical blanking seen on earlier ticks;
  // ~v_prev_q covers a blanking tick immediately before this active tick.
  assign sof_cond = armed_q | ~v_prev_q;
  assign sof      = active & sof_cond;

  // The advanced mode already colours the first pixel of the new frame.
  assign mode_eff = (sof && pending_q) ? mode_q + 2'd1 : mode_q;

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_q >= 10'(i * BAR_W)) bar = 3'(i);
    end
  end

  assign border = (x_q == 10'd0) || (x_q == 10'(H_ACTIVE - 1)) ||
                  (y_q == 10'd0) || (y_q == 10'(V_ACTIVE - 1));

  always_comb begin
    colour = 12'h000;
    unique case (mode_eff)
      2'd0: colour = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      2'd1: colour = {12{x_q[CHK_LOG2] ^ y_q[CHK_LOG2]}};
      2'd2: colour = {x_q[9:6], y_q[8:5], 4'h0};
      2'd3: colour = border ? 12'hFFF : 12'h00F;
      default: colour = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge i_sclr_n) begin
    if (!i_sclr_n) begin
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
      mode_q    <= '0;
      pending_q <= 1'b0;
      h_prev_q  <= 1'b0;
      v_prev_q  <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      fs_q <= sof;

      // A request landing on the frame-start tick belongs to the next frame.
      if (sof)                  pending_q <= bus.i_mode_next;
      else if (bus.i_mode_next) pending_q <= 1'b1;

      if (tick) begin
        h_prev_q <= bus.i_haddr_en;
        v_prev_q <= bus.i_vaddr_en;
        armed_q  <= active ? 1'b0 : sof_cond;
        mode_q   <= mode_eff;
        rgb_q    <= active ? colour : 12'h000;

        if (!bus.i_haddr_en)
          x_q <= '0;
        else if (active && x_q != 10'(H_ACTIVE - 1))
          x_q <= x_q + 10'd1;

        if (!bus.i_vaddr_en)
          y_q <= '0;
        else if (h_prev_q && !bus.i_haddr_en && y_q != 10'(V_ACTIVE - 1))
          y_q <= y_q + 10'd1;
      end
    end
  end

  assign bus.o_vga_red     = rgb_q[11:8];
  assign bus.o_vga_green   = rgb_q[7:4];
  assign bus.o_vga_blue    = rgb_q[3:0];
  assign bus.o_px_x        = x_q;
  assign bus.o_px_y        = y_q;
  assign bus.o_frame_start = fs_q;
  assign bus.o_mode        = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;
  logic clk;
  logic i_sclr_n;

  vga_pattern_gen_if bus ();

  vga_pattern_gen dut (
    .clk      (clk),
    .i_sclr_n (i_sclr_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int fs_cnt    = 0;
  int bound_bad = 0;
  int blank_bad = 0;
  int hold_bad  = 0;
  int xret_bad  = 0;
  int vb_bad    = 0;
  int fs_bad    = 0;

  logic [11:0] s_rgb;
  logic [9:0]  s_x, s_y;
  logic        s_fs;
  logic [1:0]  s_mode;

  logic [1:0]  mode_first, mode_end;
  logic        fs_first;
  logic [9:0]  sat_x, y_end, y_after;
  logic [11:0] sat_rgb;
  int          fs_delta;

  logic [11:0] cap [0:479][0:639];

  always @(negedge clk) begin
    if (bus.o_frame_start === 1'b1) fs_cnt++;
    if (bus.o_px_x > 10'd639 || bus.o_px_y > 10'd479) bound_bad++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit h, input bit v, input bit mn, input int gap);
    bus.i_px_clk    = 1'b1;
    bus.i_haddr_en  = h;
    bus.i_vaddr_en  = v;
    bus.i_mode_next = mn;
    @(negedge clk);
    s_rgb  = {bus.o_vga_red, bus.o_vga_green, bus.o_vga_blue};
    s_x    = bus.o_px_x;
    s_y    = bus.o_px_y;
    s_fs   = bus.o_frame_start;
    s_mode = bus.o_mode;
    bus.i_px_clk    = 1'b0;
    bus.i_mode_next = 1'b0;
    if (!(h && v) && s_rgb !== 12'h000) blank_bad++;
    for (int g = 1; g < gap; g++) begin
      @(negedge clk);
      if ({bus.o_vga_red, bus.o_vga_green, bus.o_vga_blue} !== s_rgb) hold_bad++;
    end
  endtask

  function automatic int nact(input int yy);
    case (yy)
      0, 479:  return 640;
      32:      return 65;
      5:       return 6;
      default: return 1;
    endcase
  endfunction

  task automatic frame(input int gap, input bit req_fs, input bit req_mid);
    int fs0;
    bit mn;
    fs0 = fs_cnt;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, gap);
    if (s_y !== 10'd0 || s_x !== 10'd0) vb_bad++;
    for (int yy = 0; yy < 480; yy++) begin
      for (int xx = 0; xx < nact(yy); xx++) begin
        mn = (req_fs && yy == 0 && xx == 0) || (req_mid && xx == 0 && yy >= 240 && yy < 243);
        tick(1'b1, 1'b1, mn, gap);
        cap[yy][xx] = s_rgb;
        if (yy == 0 && xx == 0) begin
          mode_first = s_mode;
          fs_first   = s_fs;
        end
      end
      if (yy == 479) begin
        tick(1'b1, 1'b1, 1'b0, gap);
        sat_x   = s_x;
        sat_rgb = s_rgb;
      end
      tick(1'b0, 1'b1, 1'b0, gap);
      if (s_x !== 10'd0) xret_bad++;
      tick(1'b0, 1'b1, 1'b0, gap);
      if (yy == 479) y_end = s_y;
    end
    tick(1'b0, 1'b0, 1'b0, gap);
    tick(1'b0, 1'b0, 1'b0, gap);
    mode_end = s_mode;
    y_after  = s_y;
    fs_delta = fs_cnt - fs0;
    if (fs_delta != 1) fs_bad++;
  endtask

  initial begin
    bus.i_px_clk    = 1'b0;
    bus.i_haddr_en  = 1'b0;
    bus.i_vaddr_en  = 1'b0;
    bus.i_mode_next = 1'b0;
    i_sclr_n        = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_rgb",  {20'd0, bus.o_vga_red, bus.o_vga_green, bus.o_vga_blue}, 32'h0);
    chk("rst_x",    {22'd0, bus.o_px_x}, 32'd0);
    chk("rst_y",    {22'd0, bus.o_px_y}, 32'd0);
    chk("rst_fs",   {31'd0, bus.o_frame_start}, 32'd0);
    chk("rst_mode", {30'd0, bus.o_mode}, 32'd0);
    i_sclr_n = 1'b1;

    // Frame 1: mode 0 bars, px tick every 4 clk, three requests mid-frame.
    frame(4, 1'b0, 1'b1);
    chk("f1_mode_first", {30'd0, mode_first}, 32'd0);
    chk("f1_fs_first_px", {31'd0, fs_first}, 32'd1);
    chk("f1_bar_x0",   {20'd0, cap[0][0]},   32'h000);
    chk("f1_bar_x79",  {20'd0, cap[0][79]},  32'h000);
    chk("f1_bar_x80",  {20'd0, cap[0][80]},  32'h00F);
    chk("f1_bar_x160", {20'd0, cap[0][160]}, 32'h0F0);
    chk("f1_bar_x400", {20'd0, cap[0][400]}, 32'hF0F);
    chk("f1_bar_x639", {20'd0, cap[0][639]}, 32'hFFF);
    chk("f1_x_sat",    {22'd0, sat_x},   32'd639);
    chk("f1_sat_rgb",  {20'd0, sat_rgb}, 32'hFFF);
    chk("f1_y_end",    {22'd0, y_end},   32'd479);
    chk("f1_y_vblank", {22'd0, y_after}, 32'd0);
    chk("f1_fs_pulses", fs_delta, 32'd1);
    chk("f1_mode_held", {30'd0, mode_end}, 32'd0);

    // Frame 2: three requests collapsed into one advance -> checkerboard.
    frame(1, 1'b0, 1'b0);
    chk("f2_mode_first", {30'd0, mode_first}, 32'd1);
    chk("f2_chk_31_0",   {20'd0, cap[0][31]},  32'h000);
    chk("f2_chk_32_0",   {20'd0, cap[0][32]},  32'hFFF);
    chk("f2_chk_32_32",  {20'd0, cap[32][32]}, 32'h000);
    chk("f2_chk_0_32",   {20'd0, cap[32][0]},  32'hFFF);

    // Frame 3: request on the frame-start tick itself.
    frame(1, 1'b1, 1'b0);
    chk("f3_mode_first", {30'd0, mode_first}, 32'd1);
    chk("f3_mode_end",   {30'd0, mode_end},   32'd1);

    // Frame 4: deferred request applies -> gradient.
    frame(1, 1'b0, 1'b1);
    chk("f4_mode_first",  {30'd0, mode_first}, 32'd2);
    chk("f4_grad_64_32",  {20'd0, cap[32][64]},  32'h110);
    chk("f4_grad_639_479", {20'd0, cap[479][639]}, 32'h9E0);

    // Frame 5: border.
    frame(1, 1'b0, 1'b1);
    chk("f5_mode_first",   {30'd0, mode_first}, 32'd3);
    chk("f5_bord_0_100",   {20'd0, cap[100][0]},   32'hFFF);
    chk("f5_bord_5_5",     {20'd0, cap[5][5]},     32'h00F);
    chk("f5_bord_639_479", {20'd0, cap[479][639]}, 32'hFFF);

    // Frame 6: wrap 3 -> 0.
    frame(1, 1'b0, 1'b1);
    chk("f6_mode_wrap", {30'd0, mode_first}, 32'd0);
    chk("f6_bar_x80",   {20'd0, cap[0][80]}, 32'h00F);

    // Partial frame in mode 1, then asynchronous reset mid-line.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1);
    for (int xx = 0; xx < 100; xx++) tick(1'b1, 1'b1, (xx == 50), 1);
    chk("pre_rst_mode", {30'd0, s_mode}, 32'd1);
    chk("pre_rst_rgb",  {20'd0, s_rgb},  32'hFFF);
    chk("pre_rst_x",    {22'd0, s_x},    32'd100);
    bus.i_px_clk   = 1'b1;
    #2 i_sclr_n = 1'b0;
    #1;
    chk("arst_rgb",  {20'd0, bus.o_vga_red, bus.o_vga_green, bus.o_vga_blue}, 32'h0);
    chk("arst_x",    {22'd0, bus.o_px_x}, 32'd0);
    chk("arst_y",    {22'd0, bus.o_px_y}, 32'd0);
    chk("arst_fs",   {31'd0, bus.o_frame_start}, 32'd0);
    chk("arst_mode", {30'd0, bus.o_mode}, 32'd0);
    @(negedge clk);
    bus.i_px_clk = 1'b0;
    i_sclr_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1);
    chk("post_rst_fs",   {31'd0, s_fs},   32'd1);
    chk("post_rst_mode", {30'd0, s_mode}, 32'd0);
    chk("post_rst_rgb",  {20'd0, s_rgb},  32'h000);
    chk("post_rst_x",    {22'd0, s_x},    32'd1);
    for (int xx = 1; xx < 90; xx++) tick(1'b1, 1'b1, 1'b0, 1);
    chk("post_rst_x89",  {20'd0, s_rgb},  32'h00F);

    // Pending request was discarded by reset: next frame stays in mode 0.
    frame(1, 1'b0, 1'b0);
    chk("f8_mode_first", {30'd0, mode_first}, 32'd0);
    chk("f8_bar_x80",    {20'd0, cap[0][80]},  32'h00F);
    chk("f8_bar_x639",   {20'd0, cap[0][639]}, 32'hFFF);

    chk("blanking_zero",   blank_bad, 32'd0);
    chk("rgb_hold",        hold_bad,  32'd0);
    chk("coord_bounds",    bound_bad, 32'd0);
    chk("x_line_return",   xret_bad,  32'd0);
    chk("vblank_coords",   vb_bad,    32'd0);
    chk("fs_one_per_frame", fs_bad,   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-stage test-pattern source for the 640x480 VGA path.
- Consumes the pixel-clock enable from px_clk and the active-area enables from hsync/vsync.
- Tracks the current pixel coordinate and produces registered 4-bit RGB for the VGA DAC pins.
- Selects one of four built-in patterns; pattern changes are applied only at a frame boundary, so no frame is ever torn.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BAR_W, 80, colour-bar width in pixels (8 bars across H_ACTIVE).
- CHK_LOG2, 5, log2 of checkerboard square size (32 px).

Ports:
- clk  in  1  system clock.
- i_sclr_n  in  1  reset, asynchronous assert, active-low.
- i_px_clk  in  1  pixel enable, one clk cycle wide per pixel.
- i_haddr_en  in  1  high during horizontal active region.
- i_vaddr_en  in  1  high during vertical active region.
- i_mode_next  in  1  request to advance pattern; single-clk pulse, any time.
- o_vga_red  out  4  red.
- o_vga_green  out  4  green.
- o_vga_blue  out  4  blue.
- o_px_x  out  10  current column, 0..H_ACTIVE-1.
- o_px_y  out  10  current row, 0..V_ACTIVE-1.
- o_frame_start  out  1  one-clk pulse at first active pixel of a frame.
- o_mode  out  2  pattern currently displayed.

Behaviour:
- Clock domain: all state is on clk. State changes only on cycles with i_px_clk=1, except the mode request latch.
- Asynchronous reset (i_sclr_n=0) clears everything:
  - x, y, RGB, o_frame_start and o_mode all 0.
  - pending flag 0; h_prev and v_prev 0.
- Active pixel: i_haddr_en & i_vaddr_en sampled on a px tick.
- Edge detect: h_prev and v_prev hold the enables from the previous px tick.
- x counter:
  - On an active tick: colour is computed from the current x, then x increments.
  - x saturates at H_ACTIVE-1 if extra active ticks arrive.
  - On any px tick with i_haddr_en=0, x goes to 0.
- y counter:
  - On a px tick where h_prev=1, i_haddr_en=0 and i_vaddr_en=1 (end of an active line), y increments.
  - y saturates at V_ACTIVE-1.
  - On any px tick with i_vaddr_en=0, y goes to 0.
- Frame start: on the first active tick after a px tick with v_prev=0 (or after reset), o_frame_start pulses 1 for exactly one clk.
- Mode change:
  - i_mode_next sets the pending flag on any clk.
  - At the frame-start tick, if pending: o_mode <= o_mode+1 (wraps 3 -> 0), pending cleared.
  - The new mode applies to that same first pixel.
  - i_mode_next coinciding with the frame-start tick is held pending for the next frame.
  - Multiple requests within one frame advance by only 1.
- Patterns, computed from the coordinate on the active tick:
  - Mode 0, colour bars: idx = x / BAR_W, values 0..7. RGB = {idx[2]?F:0, idx[1]?F:0, idx[0]?F:0}, so bar 0 is black and bar 7 is white.
  - Mode 1, checkerboard: (x[CHK_LOG2] ^ y[CHK_LOG2]) ? FFF : 000.
  - Mode 2, gradient: R = x[9:6], G = y[8:5], B = 0.
  - Mode 3, border: x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 gives FFF; otherwise 00F.
- RGB output timing:
  - RGB is registered; it updates 1 clk after the active tick and holds until the next px tick.
  - On any non-active px tick, RGB <= 0 (blanking). It must be 0 for the whole blanking interval.
- o_px_x and o_px_y are the registered counter values (the next pixel to be drawn).
- Reset mid-frame: all outputs go to 0 immediately. Output resumes only after a fresh frame start; the first partial frame after reset is still drawn, starting at coordinates reached from 0.

Test Plan:
- Reset, then full frame (800x525 timing, px tick every 4 clk), mode 0 -> pixels at x=0, 79, 80, 639 give RGB 000, 000, 00F, FFF. RGB is 0 in all blanking. o_frame_start is exactly one pulse per frame.
- Counter bounds -> o_px_x never exceeds 639 and o_px_y never exceeds 479. x returns to 0 after each line. y reaches 479 at the last line, then 0 during vertical blanking.
- Mode 1 at (31,0), (32,0), (32,32) -> 000, FFF, 000. Mode 3 at (0,100), (5,5), (639,479) -> FFF, 00F, FFF.
- Pulse i_mode_next mid-frame 3 times -> o_mode unchanged until the next o_frame_start, then +1 only. Pulse on the same clk as frame start -> applied at the following frame. From mode 3, one request -> 0.
- Assert i_sclr_n=0 asynchronously mid-line (between clk edges) -> all outputs read 0 before the next edge. After release, the first frame start shows o_mode=0 and correct bars.
- Mode 2 at (64,32) -> R=1, G=1, B=0. At (639,479) -> R=9, G=E.
